// File: rtl/iiitb_aclock_set.sv
// iiitb_aclock_set: pushbutton front end for setting the time or the alarm
// of a BCD alarm clock. Three raw buttons are synchronized and debounced.
// Their press events drive a small edit FSM that preloads, increments and
// finally loads either the clock time (LD_time) or an internal alarm shadow
// (LD_alarm).
// Optional feature: define AUTOREPEAT_EN to make a held inc button repeat
// every REPEAT_CYCLES cycles while editing. Without the macro, every press
// gives exactly one increment.
module iiitb_aclock_set #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 600,
  parameter int REPEAT_CYCLES  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [1:0] H_cur1,
  input  logic [3:0] H_cur0,
  input  logic [3:0] M_cur1,
  input  logic [3:0] M_cur0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [1:0] field,
  output logic       target
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // Parameter sanity check at elaboration time.
  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("iiitb_aclock_set: DEB_CYCLES/REPEAT_CYCLES must be >= 1, TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_EDIT_H, S_EDIT_M, S_COMMIT} state_t;

  // Button index: 0 = mode, 1 = inc, 2 = ok.
  logic [2:0] btn_raw;
  logic [2:0] press;
`ifdef AUTOREPEAT_EN
  logic [2:0] level;
`endif
  assign btn_raw = {btn_ok, btn_inc, btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, armed_q, armed_d, press_q, press_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Debounce. After reset a button is disarmed until a stable low is seen,
    // so a button held through reset never produces a press.
    always_comb begin
      deb_d   = deb_q;
      armed_d = armed_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (!armed_q) begin
        if (!sync2_q) begin
          if (cnt_q == DEB_LAST) armed_d = 1'b1;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end else if (sync2_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d   = sync2_q;
          press_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Two-flop synchronizer and debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        armed_q <= armed_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[gi] = press_q;
`ifdef AUTOREPEAT_EN
    assign level[gi] = deb_q;
`endif
  end

  state_t        state_q, state_d;
  logic          target_q, target_d;
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [1:0]    al_h1_q, al_h1_d;
  logic [3:0]    al_h0_q, al_h0_d, al_m1_q, al_m1_d, al_m0_q, al_m0_d;
  logic [TW-1:0] to_q, to_d;
  logic          rep_evt;
  logic          ok_evt, mode_evt, inc_evt, any_evt;

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);
  logic [RW-1:0] rep_q, rep_d;

  // Auto-repeat: rep_q counts cycles since the last inc event while inc is
  // held in an edit state; zero means repeat is inactive.
  always_comb begin
    rep_d   = '0;
    rep_evt = 1'b0;
    if ((state_q == S_EDIT_H || state_q == S_EDIT_M) && level[1]) begin
      if (press[1]) begin
        rep_d = RW'(1);
      end else if (rep_q == REP_LAST) begin
        rep_evt = 1'b1;
        rep_d   = RW'(1);
      end else if (rep_q != '0) begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  // Auto-repeat counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_evt = 1'b0;
`endif

  // Same-cycle events resolve ok > mode > inc; only the winner acts.
  assign ok_evt   = press[2];
  assign mode_evt = press[0] & ~press[2];
  assign inc_evt  = (press[1] | rep_evt) & ~press[2] & ~press[0];
  assign any_evt  = (|press) | rep_evt;

  // Edit FSM: next state, edit value, alarm shadow and timeout counter.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    al_h1_d  = al_h1_q;
    al_h0_d  = al_h0_q;
    al_m1_d  = al_m1_q;
    al_m0_d  = al_m0_q;
    to_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (mode_evt) begin
          state_d  = S_EDIT_H;
          target_d = 1'b0;
          h1_d = H_cur1; h0_d = H_cur0; m1_d = M_cur1; m0_d = M_cur0;
        end else if (inc_evt) begin
          state_d  = S_EDIT_H;
          target_d = 1'b1;
          h1_d = al_h1_q; h0_d = al_h0_q; m1_d = al_m1_q; m0_d = al_m0_q;
        end
      end
      S_EDIT_H, S_EDIT_M: begin
        to_d = any_evt ? '0 : to_q + 1'b1;
        if (ok_evt) begin
          state_d = S_COMMIT;
        end else if (mode_evt) begin
          state_d = (state_q == S_EDIT_H) ? S_EDIT_M : S_EDIT_H;
        end else if (inc_evt) begin
          if (state_q == S_EDIT_H) begin
            if (h1_q == 2'd2 && h0_q == 4'd3) begin
              h1_d = 2'd0; h0_d = 4'd0;
            end else if (h0_q == 4'd9) begin
              h1_d = h1_q + 2'd1; h0_d = 4'd0;
            end else begin
              h0_d = h0_q + 4'd1;
            end
          end else begin
            // Minutes wrap 59 -> 00 without touching the hours.
            if (m0_q == 4'd9) begin
              m0_d = 4'd0;
              m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
            end else begin
              m0_d = m0_q + 4'd1;
            end
          end
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          to_d    = '0;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (target_q) begin
          al_h1_d = h1_q; al_h0_d = h0_q; al_m1_d = m1_q; al_m0_d = m0_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, edit value, alarm shadow and timeout registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      target_q <= 1'b0;
      h1_q     <= '0;
      h0_q     <= '0;
      m1_q     <= '0;
      m0_q     <= '0;
      al_h1_q  <= '0;
      al_h0_q  <= '0;
      al_m1_q  <= '0;
      al_m0_q  <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      al_h1_q  <= al_h1_d;
      al_h0_q  <= al_h0_d;
      al_m1_q  <= al_m1_d;
      al_m0_q  <= al_m0_d;
      to_q     <= to_d;
    end
  end

  // Strobes come straight from the COMMIT state so they cannot overlap.
  always_comb begin
    LD_time  = (state_q == S_COMMIT) && !target_q;
    LD_alarm = (state_q == S_COMMIT) && target_q;
    case (state_q)
      S_EDIT_H: field = 2'b01;
      S_EDIT_M: field = 2'b10;
      default:  field = 2'b00;
    endcase
  end

  assign target = target_q;
  assign H_in1  = h1_q;
  assign H_in0  = h0_q;
  assign M_in1  = m1_q;
  assign M_in0  = m0_q;

endmodule
